// File: rtl/ti_sbox_seq.sv
`default_nettype none
// ============================================================================
// Module   : ti_sbox_seq
// Purpose  : Sequencer for a multi-stage threshold-implementation S-box.
//            Owns the inter-stage share register, drives a shared stage
//            network and remasks the shares between stages.
// Revision : 1.0  initial release
// ============================================================================
module ti_sbox_seq #(
    parameter int SHARES = 3,
    parameter int WIDTH  = 8,
    parameter int STAGES = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SHARES*WIDTH-1:0]     in_shares,
    input  logic                        rnd_valid,
    output logic                        rnd_ready,
    input  logic [(SHARES-1)*WIDTH-1:0] rnd,
    output logic [1:0]                  stg_sel,
    output logic [SHARES*WIDTH-1:0]     stg_in,
    input  logic [SHARES*WIDTH-1:0]     stg_out,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SHARES*WIDTH-1:0]     out_shares,
    output logic                        busy
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_EVAL   = 2'd1;
    localparam logic [1:0] c_REMASK = 2'd2;
    localparam logic [1:0] c_OUT    = 2'd3;
    localparam logic [1:0] c_LAST   = 2'(STAGES - 1);

    logic [1:0]              r_state;
    logic [1:0]              r_k;
    logic [SHARES*WIDTH-1:0] r_s;
    logic                    r_in_ready;
    logic                    r_rnd_ready;
    logic                    r_out_valid;
    logic                    r_busy;

    logic [WIDTH-1:0]        w_rnd_xor;
    logic [SHARES*WIDTH-1:0] w_remask;

    // The last share absorbs the XOR of all masks so the share sum is unchanged.
    always_comb begin
        w_rnd_xor = '0;
        w_remask  = r_s;
        for (int i = 0; i < SHARES - 1; i++) begin
            w_rnd_xor                 = w_rnd_xor ^ rnd[i*WIDTH +: WIDTH];
            w_remask[i*WIDTH +: WIDTH] = r_s[i*WIDTH +: WIDTH] ^ rnd[i*WIDTH +: WIDTH];
        end
        w_remask[(SHARES-1)*WIDTH +: WIDTH] = r_s[(SHARES-1)*WIDTH +: WIDTH] ^ w_rnd_xor;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_k         <= 2'd0;
            r_s         <= '0;
            r_in_ready  <= 1'b1;
            r_rnd_ready <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_s        <= in_shares;
                        r_k        <= 2'd0;
                        r_state    <= c_EVAL;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                c_EVAL: begin
                    r_s <= stg_out;
                    if (r_k == c_LAST) begin
                        r_state     <= c_OUT;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_state     <= c_REMASK;
                        r_rnd_ready <= 1'b1;
                    end
                end
                c_REMASK: begin
                    if (rnd_valid) begin
                        r_s         <= w_remask;
                        r_k         <= r_k + 2'd1;
                        r_state     <= c_EVAL;
                        r_rnd_ready <= 1'b0;
                    end
                end
                c_OUT: begin
                    if (out_ready) begin
                        r_state     <= c_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= c_IDLE;
                    r_in_ready  <= 1'b1;
                    r_rnd_ready <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // The stage network only ever sees the register, never a raw input.
    assign stg_sel    = r_k;
    assign stg_in     = r_s;
    assign out_shares = r_s;
    assign in_ready   = r_in_ready;
    assign rnd_ready  = r_rnd_ready;
    assign out_valid  = r_out_valid;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ti_sbox_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ti_sbox_seq
// Purpose  : Self-checking bench for ti_sbox_seq with a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ti_sbox_seq;

    localparam int SHARES = 3;
    localparam int WIDTH  = 8;
    localparam int STAGES = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_shares = '0;
    logic        rnd_valid = 1'b0;
    logic        rnd_ready;
    logic [15:0] rnd = '0;
    logic [1:0]  stg_sel;
    logic [23:0] stg_in;
    logic [23:0] stg_out;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [23:0] out_shares;
    logic        busy;

    bit          nonlin = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] op_rnd [STAGES-1];
    logic [15:0] fixed_words [2];

    always #5 clk = ~clk;

    ti_sbox_seq #(.SHARES(SHARES), .WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_shares(in_shares),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd(rnd),
        .stg_sel(stg_sel), .stg_in(stg_in), .stg_out(stg_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_shares(out_shares),
        .busy(busy)
    );

    // Bench stage network: identity, or a quadratic share mix.
    function automatic logic [23:0] net(input logic [1:0] k, input logic [23:0] x, input bit nl);
        logic [7:0] a, b, c;
        a = x[7:0];
        b = x[15:8];
        c = x[23:16];
        if (!nl) return x;
        return {c ^ (a & b) ^ {6'd0, k}, b ^ (c & a) ^ 8'h5A, a ^ (b & c) ^ {k, 6'd0}};
    endfunction

    always_comb stg_out = net(stg_sel, stg_in, nonlin);

    function automatic logic [23:0] golden(input logic [23:0] din, input bit nl);
        logic [23:0] s;
        logic [7:0]  r0, r1;
        s = din;
        for (int k = 0; k < STAGES; k++) begin
            s = net(2'(k), s, nl);
            if (k < STAGES - 1) begin
                r0 = op_rnd[k][7:0];
                r1 = op_rnd[k][15:8];
                s  = {s[23:16] ^ r0 ^ r1, s[15:8] ^ r1, s[7:0] ^ r0};
            end
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One transaction up to the edge where out_valid rises.
    task automatic do_op(input logic [23:0] din, input int stall, input bit fixed, output int lat);
        int          nr;
        int          seq_n;
        int          st;
        logic [23:0] held;
        nr = 0; seq_n = 0; lat = 0; st = stall;
        in_shares = din;
        in_valid  = 1'b1;
        tick;
        in_valid  = 1'b0;
        in_shares = 24'($urandom);
        chk("accept_in_ready", 24'(in_ready), 24'd0);
        chk("accept_busy", 24'(busy), 24'd1);
        while (!out_valid && lat < 50) begin
            if (busy && !rnd_ready && !out_valid) begin
                chk($sformatf("stg_sel_eval%0d", seq_n), 24'(stg_sel), 24'(seq_n));
                seq_n++;
            end
            if (rnd_ready) begin
                if (st > 0) begin
                    rnd_valid = 1'b0;
                    rnd  = 16'($urandom);
                    held = stg_in;
                    st--;
                    tick;
                    lat++;
                    chk("stall_hold_s", stg_in, held);
                    chk("stall_rnd_ready", 24'(rnd_ready), 24'd1);
                    continue;
                end
                rnd_valid = 1'b1;
                rnd = fixed ? fixed_words[nr % 2] : 16'($urandom);
                if (nr < STAGES - 1) op_rnd[nr] = rnd;
                nr++;
            end else begin
                rnd_valid = 1'($urandom_range(0, 1));
                rnd = 16'($urandom);
            end
            tick;
            lat++;
        end
        rnd_valid = 1'b0;
        chk("op_timeout", 24'(out_valid), 24'd1);
        chk("eval_count", 24'(seq_n), 24'(STAGES));
    endtask

    initial begin
        int          lat;
        int          cyc;
        int          results;
        int          last_acc;
        int          idx;
        int          nr;
        bit          seen;
        bit          acc;
        logic [23:0] held;
        logic [23:0] cur_in;
        logic [23:0] din_q [10];

        fixed_words[0] = 16'h1122;
        fixed_words[1] = 16'h3344;

        // Reset
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        chk("rst_in_ready", 24'(in_ready), 24'd1);
        chk("rst_rnd_ready", 24'(rnd_ready), 24'd0);
        chk("rst_out_valid", 24'(out_valid), 24'd0);
        chk("rst_busy", 24'(busy), 24'd0);
        chk("rst_stg_sel", 24'(stg_sel), 24'd0);
        chk("rst_stg_in", stg_in, 24'd0);
        chk("rst_out_shares", out_shares, 24'd0);
        tick;
        chk("idle_in_ready", 24'(in_ready), 24'd1);
        chk("idle_busy", 24'(busy), 24'd0);

        // Directed identity-network run with known masks
        nonlin = 1'b0;
        out_ready = 1'b1;
        do_op(24'h0000A5, 0, 1'b1, lat);
        chk("latency", 24'(lat), 24'd5);
        chk("result_directed", out_shares, 24'h4422C3);
        chk("share_xor", 24'(out_shares[7:0] ^ out_shares[15:8] ^ out_shares[23:16]), 24'hA5);
        chk("result_model", out_shares, golden(24'h0000A5, 1'b0));
        tick;
        chk("post_out_idle", 24'(in_ready), 24'd1);
        chk("post_out_valid", 24'(out_valid), 24'd0);

        // Randomness stall in the first REMASK
        do_op(24'h0000A5, 3, 1'b1, lat);
        chk("stall_latency", 24'(lat), 24'd8);
        chk("stall_result", out_shares, 24'h4422C3);
        tick;

        // Output backpressure, with in_valid asserted to show it is ignored
        out_ready = 1'b0;
        cur_in = 24'($urandom);
        do_op(cur_in, 0, 1'b0, lat);
        chk("bp_result", out_shares, golden(cur_in, 1'b0));
        held = out_shares;
        in_valid  = 1'b1;
        in_shares = 24'($urandom);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("bp_out_valid", 24'(out_valid), 24'd1);
            chk("bp_out_hold", out_shares, held);
            chk("bp_in_ready", 24'(in_ready), 24'd0);
        end
        out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        chk("bp_release_idle", 24'(in_ready), 24'd1);
        chk("bp_release_busy", 24'(busy), 24'd0);
        chk("bp_release_valid", 24'(out_valid), 24'd0);
        chk("bp_release_hold", out_shares, held);

        // Reset during the second EVAL
        in_shares = 24'($urandom);
        in_valid  = 1'b1;
        tick;
        in_valid  = 1'b0;
        rnd_valid = 1'b1;
        rnd = 16'($urandom);
        tick;
        tick;
        chk("mid_eval_sel", 24'(stg_sel), 24'd1);
        chk("mid_eval_rnd_ready", 24'(rnd_ready), 24'd0);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        chk("mid_rst_in_ready", 24'(in_ready), 24'd1);
        chk("mid_rst_busy", 24'(busy), 24'd0);
        chk("mid_rst_s", stg_in, 24'd0);
        chk("mid_rst_sel", 24'(stg_sel), 24'd0);
        seen = (out_valid === 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick;
            if (out_valid) seen = 1'b1;
        end
        rnd_valid = 1'b0;
        chk("mid_rst_no_out", 24'(seen), 24'd0);

        // Back-to-back random operation through the nonlinear network
        nonlin = 1'b1;
        for (int i = 0; i < 10; i++) din_q[i] = 24'($urandom);
        idx = 0; cyc = 0; results = 0; last_acc = -1; nr = 0; cur_in = '0;
        in_shares = din_q[0];
        in_valid  = 1'b1;
        rnd_valid = 1'b1;
        while (results < 10 && cyc < 300) begin
            rnd = 16'($urandom);
            if (busy) chk("b2b_busy_not_ready", 24'(in_ready), 24'd0);
            acc = in_valid && in_ready;
            if (rnd_valid && rnd_ready && nr < STAGES - 1) begin
                op_rnd[nr] = rnd;
                nr++;
            end
            if (acc) begin
                cur_in = in_shares;
                nr = 0;
                if (last_acc >= 0) chk("b2b_period", 24'(cyc - last_acc), 24'd7);
                last_acc = cyc;
                idx++;
            end
            tick;
            cyc++;
            if (acc) begin
                in_valid  = (idx < 10);
                in_shares = (idx < 10) ? din_q[idx] : 24'($urandom);
            end
            if (out_valid) begin
                chk($sformatf("b2b_result%0d", results), out_shares, golden(cur_in, 1'b1));
                results++;
            end
        end
        in_valid  = 1'b0;
        rnd_valid = 1'b0;
        chk("b2b_result_count", 24'(results), 24'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
